// File: rtl/bin_to_bcd_pkg.sv
`default_nettype none
// bin_to_bcd_pkg: FSM state type and sizing helpers shared by the converter.
package bin_to_bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic longint unsigned pow10(input int n);
    longint unsigned p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

  function automatic int cnt_width(input int in_width);
    return $clog2(in_width + 1);
  endfunction

  localparam int DEF_IN_WIDTH = 14;
  localparam int DEF_DIGITS   = 4;

  localparam longint unsigned BCD_MAX = pow10(DEF_DIGITS) - 64'd1;
  localparam int              CNT_W   = $clog2(DEF_IN_WIDTH + 1);

endpackage
`default_nettype wire

// File: rtl/bcd_digit_adj.sv
`default_nettype none
// bcd_digit_adj: double-dabble digit correction, adds 3 to any digit >= 5.
module bcd_digit_adj (
  input  logic [3:0] digit,
  output logic [3:0] adj
);

  assign adj = (digit >= 4'd5) ? digit + 4'd3 : digit;

endmodule
`default_nettype wire

// File: rtl/bin_to_bcd.sv
`default_nettype none
// bin_to_bcd: sequential double-dabble converter, one bit per clock, fixed latency.
module bin_to_bcd
  import bin_to_bcd_pkg::*;
#(
  parameter int IN_WIDTH = 14,
  parameter int DIGITS   = 4
) (
  input  logic                  clk_pi,
  input  logic                  rst_n_pi,
  input  logic                  start_pi,
  input  logic [IN_WIDTH-1:0]   bin_pi,
  output logic                  busy_po,
  output logic                  done_po,
  output logic [4*DIGITS-1:0]   bcd_po,
  output logic                  ovf_po
);

  localparam int              BW      = 4 * DIGITS;
  localparam int              CW      = cnt_width(IN_WIDTH);
  localparam longint unsigned MAX_VAL = pow10(DIGITS) - 64'd1;
  localparam logic [CW-1:0]   LAST    = CW'(IN_WIDTH - 1);

  state_t              state;
  state_t              state_nx;
  logic [BW-1:0]       acc;
  logic [BW-1:0]       acc_adj;
  logic [IN_WIDTH-1:0] sr;
  logic [CW-1:0]       cnt;
  logic                ovf_cap;
  logic                over;

  always_ff @(posedge clk_pi) begin
    if (!rst_n_pi) state <= IDLE;
    else           state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start_pi) state_nx = SHIFT;
      SHIFT:   if (cnt == LAST) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign busy_po = (state != IDLE);

  generate
    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
      bcd_digit_adj u_adj (
        .digit (acc[4*g +: 4]),
        .adj   (acc_adj[4*g +: 4])
      );
    end
  endgenerate

  // Overflow is decided once, from the raw input, so the shifter never has to detect it.
  assign over = (64'(bin_pi) > MAX_VAL);

  always_ff @(posedge clk_pi) begin
    if (!rst_n_pi) begin
      acc     <= '0;
      sr      <= '0;
      cnt     <= '0;
      ovf_cap <= 1'b0;
      bcd_po  <= '0;
      ovf_po  <= 1'b0;
      done_po <= 1'b0;
    end else begin
      done_po <= 1'b0;
      case (state)
        IDLE: begin
          if (start_pi) begin
            sr      <= bin_pi;
            acc     <= '0;
            cnt     <= '0;
            ovf_cap <= over;
          end
        end
        SHIFT: begin
          acc <= {acc_adj[BW-2:0], sr[IN_WIDTH-1]};
          sr  <= {sr[IN_WIDTH-2:0], 1'b0};
          cnt <= cnt + CW'(1);
        end
        DONE: begin
          done_po <= 1'b1;
          ovf_po  <= ovf_cap;
          bcd_po  <= ovf_cap ? {DIGITS{4'h9}} : acc;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
